// File: rtl/keypad_pkg.sv
// Shared keypad constants, the queued event record and the pending-event picker.
package keypad_pkg;

    localparam int KEY_COUNT  = 12;
    localparam int KEY_CODE_W = 4;

    typedef struct packed {
        logic                  is_release;
        logic [KEY_CODE_W-1:0] code;
    } key_evt_t;

    // Lowest set index wins; an all-zero vector yields 0 and must be gated by the caller.
    function automatic logic [KEY_CODE_W-1:0] lowest_key(input logic [KEY_COUNT-1:0] keys);
        logic [KEY_CODE_W-1:0] idx;
        idx = '0;
        for (int k = KEY_COUNT - 1; k >= 0; k--) begin
            if (keys[k]) idx = KEY_CODE_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Event FIFO with a registered head word; the head reads as zero while empty.
// A push is accepted on a full FIFO when a pop happens in the same cycle.
module key_event_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 5
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [AW-1:0]                     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                     rd_ptr_q, rd_ptr_d;
    logic [AW:0]                       count_q, count_d;
    logic [DATA_W-1:0]                 head_q, head_d;
    logic                              head_vld_q, head_vld_d;
    logic                              pop_ok, push_ok;

    assign o_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign o_empty = ~head_vld_q;
    assign o_head  = head_q;

    always_comb begin
        pop_ok   = i_pop && head_vld_q;
        push_ok  = i_push && (!o_full || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        if (push_ok) mem_d[wr_ptr_q] = i_push_data;

        // Next head is either an entry already stored or the word pushed this cycle.
        head_vld_d = (count_d != '0);
        head_d     = '0;
        if (head_vld_d) begin
            if (push_ok && ((count_q - (AW+1)'(pop_ok)) == '0)) head_d = i_push_data;
            else                                                 head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

endmodule

// File: rtl/keypad_event_encoder.sv
// 3x4 keypad debouncer and press/release event encoder feeding a FIFO.
// Define KEYPAD_RELEASE_EVENT_EN to queue release events; otherwise only presses are reported.
module keypad_event_encoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [KEY_COUNT-1:0]  i_key_raw,
    output logic [KEY_COUNT-1:0]  o_key_stable,
    output logic                  o_evt_valid,
    input  logic                  i_evt_ready,
    output logic [KEY_CODE_W-1:0] o_evt_code,
    output logic                  o_evt_release,
    output logic                  o_overflow,
    input  logic                  i_overflow_clr
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEYPAD_RELEASE_EVENT_EN
    localparam int DATA_W = $bits(key_evt_t);
`else
    localparam int DATA_W = KEY_CODE_W;
`endif

    logic [KEY_COUNT-1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [KEY_COUNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_COUNT-1:0]            stable_q, stable_d, stable_dly_q, stable_dly_d;
    logic [KEY_COUNT-1:0]            press_pend_q, press_pend_d, press_clr;
    logic [KEY_COUNT-1:0]            rise, sel_mask;
    logic                            overflow_q, overflow_d, ovf_hit;
    logic                            evt_avail, sel_rel;
    logic [KEY_CODE_W-1:0]           sel_code;
    logic                            fifo_push, fifo_pop, fifo_accept;
    logic                            fifo_full, fifo_empty;
    logic [DATA_W-1:0]               fifo_push_data, fifo_head;

`ifdef KEYPAD_RELEASE_EVENT_EN
    logic [KEY_COUNT-1:0]            rel_pend_q, rel_pend_d, rel_clr, fall;
    key_evt_t                        head_evt;
`endif

    // Synchronizer and per-key debounce: the counter only runs while the
    // synchronized level disagrees with the accepted level.
    always_comb begin
        sync1_d      = i_key_raw;
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;
        stable_d     = stable_q;
        cnt_d        = cnt_q;
        for (int k = 0; k < KEY_COUNT; k++) begin
            if (sync2_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_LAST) begin
                cnt_d[k]    = '0;
                stable_d[k] = ~stable_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    assign fifo_pop    = o_evt_valid && i_evt_ready;
    assign fifo_accept = !fifo_full || fifo_pop;

    // Pending-event bookkeeping: presses drain before releases, lowest key first.
    always_comb begin
        rise      = stable_q & ~stable_dly_q;
        sel_rel   = 1'b0;
        sel_code  = lowest_key(press_pend_q);
        evt_avail = |press_pend_q;
`ifdef KEYPAD_RELEASE_EVENT_EN
        fall = ~stable_q & stable_dly_q;
        if (!(|press_pend_q) && (|rel_pend_q)) begin
            sel_rel   = 1'b1;
            sel_code  = lowest_key(rel_pend_q);
            evt_avail = 1'b1;
        end
`endif
        fifo_push    = evt_avail && fifo_accept;
        sel_mask     = KEY_COUNT'(1) << sel_code;
        press_clr    = (fifo_push && !sel_rel) ? sel_mask : '0;
        press_pend_d = (press_pend_q & ~press_clr) | rise;
        // An edge landing on a still-pending bit merges into it and is reported as lost.
        ovf_hit      = |(rise & press_pend_q & ~press_clr);
`ifdef KEYPAD_RELEASE_EVENT_EN
        rel_clr        = (fifo_push && sel_rel) ? sel_mask : '0;
        rel_pend_d     = (rel_pend_q & ~rel_clr) | fall;
        ovf_hit        = ovf_hit | (|(fall & rel_pend_q & ~rel_clr));
        fifo_push_data = key_evt_t'({sel_rel, sel_code});
`else
        fifo_push_data = sel_code;
`endif
        overflow_d = overflow_q;
        if (ovf_hit)             overflow_d = 1'b1;
        else if (i_overflow_clr) overflow_d = 1'b0;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            cnt_q        <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            press_pend_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            press_pend_q <= press_pend_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef KEYPAD_RELEASE_EVENT_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) rel_pend_q <= '0;
        else        rel_pend_q <= rel_pend_d;
    end
`endif

    key_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .aclk        (aclk),
        .areset      (areset),
        .i_push      (fifo_push),
        .i_push_data (fifo_push_data),
        .i_pop       (i_evt_ready),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_head      (fifo_head)
    );

    assign o_key_stable = stable_q;
    assign o_evt_valid  = !fifo_empty;
    assign o_overflow   = overflow_q;

`ifdef KEYPAD_RELEASE_EVENT_EN
    assign head_evt      = key_evt_t'(fifo_head);
    assign o_evt_code    = head_evt.code;
    assign o_evt_release = head_evt.is_release;
`else
    assign o_evt_code    = fifo_head;
    assign o_evt_release = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Directed bench for keypad_event_encoder with a queue scoreboard checked by a monitor.
module tb_keypad_event_encoder;
    import keypad_pkg::*;

`ifdef KEYPAD_RELEASE_EVENT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic                  aclk = 1'b0;
    logic                  areset = 1'b1;
    logic [KEY_COUNT-1:0]  i_key_raw = '0;
    logic [KEY_COUNT-1:0]  o_key_stable;
    logic                  o_evt_valid;
    logic                  i_evt_ready = 1'b0;
    logic [KEY_CODE_W-1:0] o_evt_code;
    logic                  o_evt_release;
    logic                  o_overflow;
    logic                  i_overflow_clr = 1'b0;

    typedef struct { logic [3:0] code; logic rel; } exp_t;
    exp_t sb[$];
    exp_t got_e;
    int   total = 0;
    int   bad   = 0;

    keypad_event_encoder #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(2)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .i_key_raw      (i_key_raw),
        .o_key_stable   (o_key_stable),
        .o_evt_valid    (o_evt_valid),
        .i_evt_ready    (i_evt_ready),
        .o_evt_code     (o_evt_code),
        .o_evt_release  (o_evt_release),
        .o_overflow     (o_overflow),
        .i_overflow_clr (i_overflow_clr)
    );

    always #5 aclk = ~aclk;

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic exp_evt(input int code, input bit rel);
        exp_t e;
        e.code = 4'(code);
        e.rel  = rel;
        sb.push_back(e);
    endtask

    task automatic exp_rel(input int code);
        if (REL_EN) exp_evt(code, 1'b1);
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge aclk) begin
        if (!areset && o_evt_valid && i_evt_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL evt_unexpected: got code=%0d rel=%0d want none", o_evt_code, o_evt_release);
            end else begin
                got_e = sb.pop_front();
                if (o_evt_code !== got_e.code || o_evt_release !== got_e.rel) begin
                    bad++;
                    $display("FAIL evt: got code=%0d rel=%0d want code=%0d rel=%0d",
                             o_evt_code, o_evt_release, got_e.code, got_e.rel);
                end
            end
        end
    end

    initial begin
        bit seen;

        tick(3);
        chk("rst_stable", 32'(o_key_stable), 32'h0);
        chk("rst_valid", 32'(o_evt_valid), 32'h0);
        chk("rst_code", 32'(o_evt_code), 32'h0);
        chk("rst_ovf", 32'(o_overflow), 32'h0);
        areset = 1'b0;
        tick(2);

        // Single press latency: stable after 6 edges, valid after 8.
        i_key_raw[5] = 1'b1;
        exp_evt(5, 1'b0);
        tick(5);
        chk("k5_stable_c5", 32'(o_key_stable[5]), 32'h0);
        tick(1);
        chk("k5_stable_c6", 32'(o_key_stable[5]), 32'h1);
        tick(1);
        chk("k5_valid_c7", 32'(o_evt_valid), 32'h0);
        tick(1);
        chk("k5_valid_c8", 32'(o_evt_valid), 32'h1);
        chk("k5_code_c8", 32'(o_evt_code), 32'd5);
        i_evt_ready = 1'b1;
        tick(3);
        chk("idle_valid", 32'(o_evt_valid), 32'h0);
        chk("idle_code", 32'(o_evt_code), 32'h0);

        // Three-cycle glitch on key 2 is filtered.
        i_key_raw[2] = 1'b1;
        tick(3);
        i_key_raw[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (o_key_stable[2] || o_evt_valid) seen = 1'b1;
        end
        chk("glitch_no_change", 32'(seen), 32'h0);

        // Simultaneous presses drain lowest index first on consecutive cycles.
        i_key_raw[0] = 1'b1; i_key_raw[7] = 1'b1; i_key_raw[11] = 1'b1;
        exp_evt(0, 1'b0); exp_evt(7, 1'b0); exp_evt(11, 1'b0);
        tick(8);
        chk("multi_code0", 32'(o_evt_code), 32'd0);
        tick(1);
        chk("multi_code7", 32'(o_evt_code), 32'd7);
        tick(1);
        chk("multi_code11", 32'(o_evt_code), 32'd11);
        tick(1);
        chk("multi_done", 32'(o_evt_valid), 32'h0);

        i_key_raw = '0;
        exp_rel(0); exp_rel(5); exp_rel(7); exp_rel(11);
        tick(12);

        // FIFO full holds the third press until the consumer drains.
        i_evt_ready = 1'b0;
        i_key_raw[1] = 1'b1; i_key_raw[2] = 1'b1; i_key_raw[3] = 1'b1;
        exp_evt(1, 1'b0); exp_evt(2, 1'b0); exp_evt(3, 1'b0);
        tick(14);
        chk("full_valid", 32'(o_evt_valid), 32'h1);
        chk("full_head", 32'(o_evt_code), 32'd1);
        chk("full_ovf", 32'(o_overflow), 32'h0);
        i_evt_ready = 1'b1;
        tick(5);
        chk("drain_ovf", 32'(o_overflow), 32'h0);
        chk("drain_valid", 32'(o_evt_valid), 32'h0);

        i_key_raw = '0;
        exp_rel(1); exp_rel(2); exp_rel(3);
        tick(12);

        // Re-press of key 4 while its press is still pending sets overflow.
        i_evt_ready = 1'b0;
        i_key_raw[1] = 1'b1; i_key_raw[2] = 1'b1;
        exp_evt(1, 1'b0); exp_evt(2, 1'b0);
        tick(12);
        i_key_raw[4] = 1'b1;
        exp_evt(4, 1'b0);
        tick(8);
        chk("ovf_before", 32'(o_overflow), 32'h0);
        i_key_raw[4] = 1'b0;
        exp_rel(4);
        tick(8);
        i_key_raw[4] = 1'b1;
        tick(8);
        chk("ovf_set", 32'(o_overflow), 32'h1);
        i_overflow_clr = 1'b1;
        tick(1);
        i_overflow_clr = 1'b0;
        chk("ovf_clr", 32'(o_overflow), 32'h0);
        i_evt_ready = 1'b1;
        tick(8);
        chk("ovf_after_drain", 32'(o_overflow), 32'h0);

        i_key_raw = '0;
        exp_rel(1); exp_rel(2); exp_rel(4);
        tick(12);

        // Press then release of key 9.
        i_key_raw[9] = 1'b1;
        exp_evt(9, 1'b0);
        tick(10);
        i_key_raw[9] = 1'b0;
        exp_rel(9);
        tick(10);

        // Reset mid-queue discards events; a key held through reset re-reports.
        i_evt_ready = 1'b0;
        i_key_raw[6] = 1'b1; i_key_raw[8] = 1'b1;
        exp_evt(6, 1'b0); exp_evt(8, 1'b0);
        tick(12);
        chk("preq_valid", 32'(o_evt_valid), 32'h1);
        #2 areset = 1'b1;
        #1;
        chk("arst_valid", 32'(o_evt_valid), 32'h0);
        chk("arst_code", 32'(o_evt_code), 32'h0);
        chk("arst_stable", 32'(o_key_stable), 32'h0);
        sb.delete();
        i_key_raw[8] = 1'b0;
        tick(3);
        areset = 1'b0;
        exp_evt(6, 1'b0);
        i_evt_ready = 1'b1;
        tick(12);
        chk("post_rst_stable6", 32'(o_key_stable[6]), 32'h1);

        for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
        chk("sb_drain", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
